// File: rtl/apb_slave_bank.sv
// APB slave bank: NUM_SLAVES independent word memories behind a registered,
// wait-state-capable pready/pslverr handshake with deterministic read-back.
module apb_slave_bank #(
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [NUM_SLAVES-1:0] psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] pr_data,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] pr_data_q, pr_data_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_SLAVES][MEM_DEPTH];

    logic                  setup_c;
    logic                  active_c;
    logic                  oor_c;
    logic                  multi_sel_c;
    logic                  enter_ready_c;
    logic                  commit_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    assign setup_c     = (psel != '0) && !penable;
    assign active_c    = (psel != '0) && penable;
    assign oor_c       = (paddr >> (IDX_W + 2)) != '0;
    assign multi_sel_c = (psel & (psel - NUM_SLAVES'(1))) != '0;

    // Transfer sequencing; the *_d field values are what the transfer will use
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        write_d       = write_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        enter_ready_c = 1'b0;
        commit_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup_c) begin
                    sel_d   = psel;
                    write_d = pwrite;
                    idx_d   = paddr[IDX_W+1:2];
                    wdata_d = pwdata;
                    err_d   = multi_sel_c || oor_c;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d       = ST_READY;
                        enter_ready_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!active_c) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d       = ST_READY;
                        enter_ready_c = 1'b1;
                    end
                end
            end
            ST_READY: begin
                state_d  = ST_IDLE;
                commit_c = active_c && write_q && !err_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory is only written in READY, so sampling it on entry is safe
    always_comb begin
        rd_word_c = '0;
        for (int s = 0; s < int'(NUM_SLAVES); s++) begin
            if (sel_d[s]) begin
                rd_word_c = rd_word_c | mem_q[s][idx_d];
            end
        end
    end

    assign pr_data_d = (enter_ready_c && !write_d && !err_d) ? rd_word_c : '0;
    assign pready_d  = enter_ready_c;
    assign pslverr_d = enter_ready_c && err_d;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pr_data_q <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pr_data_q <= pr_data_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int s = 0; s < int'(NUM_SLAVES); s++) begin
                for (int w = 0; w < int'(MEM_DEPTH); w++) begin
                    mem_q[s][w] <= '0;
                end
            end
        end else if (commit_c) begin
            for (int s = 0; s < int'(NUM_SLAVES); s++) begin
                if (sel_q[s]) begin
                    mem_q[s][idx_q] <= wdata_q;
                end
            end
        end
    end

    assign pr_data = pr_data_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Scoreboard bench for apb_slave_bank: three instances with 0, 2 and 3 wait
// states, each driven by its own APB master task.
module tb_apb_slave_bank;

    localparam int unsigned N_DUT = 3;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        hclk;
    logic        hreset;
    logic [2:0]  psel    [N_DUT];
    logic        penable [N_DUT];
    logic        pwrite  [N_DUT];
    logic [31:0] paddr   [N_DUT];
    logic [31:0] pwdata  [N_DUT];
    logic [31:0] pr_data [N_DUT];
    logic        pready  [N_DUT];
    logic        pslverr [N_DUT];

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc_cnt  = 0;
    exp_t        sb_q [$];
    exp_t        mon_e;

    for (genvar g = 0; g < int'(N_DUT); g++) begin : g_dut
        apb_slave_bank #(
            .NUM_SLAVES  (3),
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_DEPTH   (16),
            .WAIT_STATES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .hclk    (hclk),
            .hreset  (hreset),
            .psel    (psel[g]),
            .penable (penable[g]),
            .pwrite  (pwrite[g]),
            .paddr   (paddr[g]),
            .pwdata  (pwdata[g]),
            .pr_data (pr_data[g]),
            .pready  (pready[g]),
            .pslverr (pslverr[g])
        );
    end

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int unsigned ws_of(input int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every pready pulse must match the oldest expectation
    always @(negedge hclk) begin
        for (int d = 0; d < int'(N_DUT); d++) begin
            if (pready[d]) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_pready", 32'(pready[d]), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("resp_dut", 32'(d), 32'(mon_e.dut));
                    check_eq("resp_rdata", pr_data[d], mon_e.rdata);
                    check_eq("resp_slverr", 32'(pslverr[d]), 32'(mon_e.err));
                    check_eq("resp_latency", cyc_cnt, mon_e.cyc);
                end
            end
        end
    end

    // Returns during the READY cycle with the access phase still driven
    task automatic xfer(input int d, input logic [2:0] sel, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   waited;
        @(posedge hclk); #1;
        psel[d]    = sel;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        check_eq("setup_pready", 32'(pready[d]), 32'd0);
        check_eq("setup_rdata", pr_data[d], 32'd0);
        e.dut   = 2'(d);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc_cnt + ws_of(d) + 1;
        sb_q.push_back(e);
        @(posedge hclk); #1;
        penable[d] = 1'b1;
        waited = 0;
        while (!pready[d] && waited < 40) begin
            @(posedge hclk); #1;
            waited++;
        end
        if (!pready[d]) begin
            check_eq("pready_timeout", 32'(pready[d]), 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
    endtask

    task automatic bus_idle(input int d);
        @(posedge hclk); #1;
        psel[d]    = 3'b000;
        penable[d] = 1'b0;
        check_eq("end_pready", 32'(pready[d]), 32'd0);
        check_eq("end_rdata", pr_data[d], 32'd0);
    endtask

    task automatic abort_xfer(input int d, input logic [2:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge hclk); #1;
        psel[d]    = sel;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b1;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(posedge hclk); #1;
        penable[d] = 1'b1;
        @(posedge hclk); #1;
        psel[d]    = 3'b000;
        penable[d] = 1'b0;
        repeat (4) begin
            @(posedge hclk); #1;
            check_eq("abort_pready", 32'(pready[d]), 32'd0);
        end
    endtask

    initial begin
        hreset = 1'b1;
        for (int d = 0; d < int'(N_DUT); d++) begin
            psel[d]    = 3'b000;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            paddr[d]   = 32'd0;
            pwdata[d]  = 32'd0;
        end
        repeat (2) @(posedge hclk);
        #1;
        for (int d = 0; d < int'(N_DUT); d++) begin
            check_eq("rst_pready", 32'(pready[d]), 32'd0);
            check_eq("rst_pslverr", 32'(pslverr[d]), 32'd0);
            check_eq("rst_rdata", pr_data[d], 32'd0);
        end
        hreset = 1'b0;

        // Zero wait states: basic, back-to-back, boundaries and errors
        xfer(0, 3'b001, 1'b1, 32'h8,        32'hDEADBEEF, 32'h0,        1'b0);
        xfer(0, 3'b001, 1'b0, 32'h8,        32'h0,        32'hDEADBEEF, 1'b0);
        xfer(0, 3'b010, 1'b0, 32'h8,        32'h0,        32'h0,        1'b0);
        xfer(0, 3'b001, 1'b1, 32'h0,        32'hA5A50001, 32'h0,        1'b0);
        xfer(0, 3'b010, 1'b1, 32'h3C,       32'h0BADF00D, 32'h0,        1'b0);
        xfer(0, 3'b010, 1'b0, 32'h3C,       32'h0,        32'h0BADF00D, 1'b0);
        xfer(0, 3'b001, 1'b0, 32'hB,        32'h0,        32'hDEADBEEF, 1'b0);
        xfer(0, 3'b001, 1'b1, 32'h40,       32'hFFFFFFFF, 32'h0,        1'b1);
        xfer(0, 3'b001, 1'b0, 32'h0,        32'h0,        32'hA5A50001, 1'b0);
        xfer(0, 3'b001, 1'b0, 32'h40,       32'h0,        32'h0,        1'b1);
        xfer(0, 3'b001, 1'b0, 32'h80000008, 32'h0,        32'h0,        1'b1);
        xfer(0, 3'b011, 1'b1, 32'h8,        32'h55555555, 32'h0,        1'b1);
        xfer(0, 3'b001, 1'b0, 32'h8,        32'h0,        32'hDEADBEEF, 1'b0);
        xfer(0, 3'b010, 1'b0, 32'h8,        32'h0,        32'h0,        1'b0);
        xfer(0, 3'b111, 1'b0, 32'h8,        32'h0,        32'h0,        1'b1);
        bus_idle(0);

        // Three wait states
        xfer(2, 3'b100, 1'b1, 32'h4, 32'h11111111, 32'h0,        1'b0);
        xfer(2, 3'b100, 1'b0, 32'h4, 32'h0,        32'h11111111, 1'b0);
        bus_idle(2);

        // Two wait states, then an aborted overwrite
        xfer(1, 3'b010, 1'b1, 32'h10, 32'h22222222, 32'h0,        1'b0);
        xfer(1, 3'b010, 1'b0, 32'h10, 32'h0,        32'h22222222, 1'b0);
        bus_idle(1);
        abort_xfer(1, 3'b010, 32'h10, 32'h77777777);
        xfer(1, 3'b010, 1'b0, 32'h10, 32'h0,        32'h22222222, 1'b0);
        bus_idle(1);

        // Reset during WAIT of a write
        @(posedge hclk); #1;
        psel[2]    = 3'b001;
        penable[2] = 1'b0;
        pwrite[2]  = 1'b1;
        paddr[2]   = 32'h4;
        pwdata[2]  = 32'h00001234;
        @(posedge hclk); #1;
        penable[2] = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b1;
        #1;
        check_eq("rst_wait_pready", 32'(pready[2]), 32'd0);
        check_eq("rst_wait_rdata", pr_data[2], 32'd0);
        @(posedge hclk); #1;
        psel[2]    = 3'b000;
        penable[2] = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        xfer(2, 3'b001, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        xfer(2, 3'b100, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        bus_idle(2);
        xfer(0, 3'b001, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        bus_idle(0);

        // Reset while READY is showing: pready drops at once, no commit
        xfer(0, 3'b001, 1'b1, 32'h20, 32'h0000CAFE, 32'h0, 1'b0);
        hreset = 1'b1;
        #1;
        check_eq("rst_ready_pready", 32'(pready[0]), 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(posedge hclk); #1;
        psel[0]    = 3'b000;
        penable[0] = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        xfer(0, 3'b001, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        bus_idle(0);

        repeat (2) @(posedge hclk);
        #1;
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Parametrised APB peripheral model that replaces the combinational pass-through interface with a registered, wait-state-capable slave bank for bridge-level verification.
- Holds NUM_SLAVES independent word-addressed memories, one per psel bit.
- Completes transfers with a pready/pslverr handshake after a programmable number of wait states.
- Sits on the APB side of the AHB-to-APB bridge and provides deterministic read-back in place of random data.

Parameters:
- NUM_SLAVES, 3, number of peripherals and the width of psel.
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata and pr_data width.
- MEM_DEPTH, 16, words per slave; must be a power of two and at least 2.
- WAIT_STATES, 0, wait cycles inserted before pready (0..15).

Ports:
- hclk  in  1  clock; everything is sampled on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- psel  in  NUM_SLAVES  peripheral select, expected one-hot.
- penable  in  1  APB access-phase enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pr_data  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error, valid only while pready=1.

Behaviour:
- Reset: all of the following are cleared.
  - State = IDLE, wait counter = 0, latched fields = 0.
  - All memory words = 0.
  - pr_data = 0, pready = 0, pslverr = 0.
- Address decode:
  - IDX_W = log2(MEM_DEPTH); word index = paddr[IDX_W+1:2].
  - paddr[1:0] is ignored.
  - Out-of-range when any bit of paddr[ADDR_WIDTH-1:IDX_W+2] is 1.
- Error condition (err), latched at setup: psel not one-hot (two or more bits set) OR out-of-range address.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - Setup phase is psel!=0 and penable=0.
  - On a setup phase: latch psel, pwrite, index, pwdata and err; load counter = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else READY.
  - Any other input combination leaves the FSM in IDLE.
- WAIT:
  - pready = 0.
  - If penable=0 or psel=0: abort to IDLE, no memory change, no response.
  - Otherwise decrement the counter; go to READY when the counter reaches 1.
- READY (exactly one cycle):
  - pready = 1 and pslverr = latched err.
  - If penable=0 or psel=0: same abort rule as WAIT; pready still reads 1 this cycle but no commit occurs.
  - Otherwise the transfer commits on this clock edge, then the FSM returns to IDLE.
  - Write with !err: mem[sel][index] <= latched pwdata.
  - Write with err: memory unchanged.
- pr_data:
  - Registered; loaded on the edge that enters READY.
  - Read with !err: loads mem[sel][index].
  - Write, or any err: loads 0.
  - Cleared to 0 on the edge that leaves READY.
  - Result: pr_data is non-zero only during READY of a successful read.
- Latency: setup cycle + WAIT_STATES cycles + 1 READY cycle = WAIT_STATES+2 cycles per transfer.
- Back-to-back: a new setup phase is accepted in the IDLE cycle immediately after READY, with no dead cycle beyond the APB protocol.
- Simultaneous events:
  - Read-after-write to the same word returns the new data, because the write commits before the next setup.
  - Inputs changing during WAIT/READY are ignored except penable/psel for the abort check; only latched values are used.
- Reset mid-transfer: immediate return to IDLE, no commit, memory cleared, pready=0.

Test Plan:
- Write/read, WAIT_STATES=0:
  - Write 32'hDEADBEEF to psel=3'b001, paddr=8 -> pready=1 on the 2nd cycle, pslverr=0.
  - Read of the same location -> pr_data=32'hDEADBEEF during pready.
  - Read psel=3'b010, paddr=8 -> 32'h0 (slaves are independent).
- Wait states, WAIT_STATES=3: read -> pready low for 3 access cycles and high on the 5th cycle after setup for exactly 1 cycle.
- Out-of-range address:
  - Write to paddr=32'h40 with MEM_DEPTH=16 -> pready=1, pslverr=1.
  - Subsequent read of paddr=0 -> unchanged; pr_data=0 during the error response.
- Bad select: psel=3'b011 on a write -> pslverr=1; neither slave's memory changes.
- Abort: with WAIT_STATES=2, drop penable during WAIT -> FSM goes to IDLE, pready never rises, and a later read shows no write occurred.
- Reset mid-transfer: assert hreset during WAIT after writing 32'h1234 at paddr=4 -> pready=0 immediately; a read of paddr=4 after release returns 0.
